// File: rtl/inst_queue.sv
// Two-wide instruction queue between fetch and the dual decoders.
// Circular buffer with FWFT read of the oldest two entries and a one-cycle flush.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             in_valid1,
  input  logic             in_valid2,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_inst2,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_pc2,
  input  logic             in_pred1,
  input  logic             in_pred2,
  output logic             in_ready,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_inst2,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_pc2,
  output logic             out_pred1,
  output logic             out_pred2,
  input  logic [1:0]       deq_num,
  input  logic             flush,
  output logic [PTR_W:0]   count
);
  localparam int NUM_LANES = 2;
  localparam logic [31:0]    NOP     = 32'h0000_0013;
  localparam logic [PTR_W:0] CNT_RDY = (PTR_W+1)'(DEPTH - 2);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  entry_t                            mem [DEPTH];
  logic [PTR_W-1:0]                  head, tail;
  logic [1:0]                        enq_num, deq_req, deq_eff;
  logic [NUM_LANES-1:0][PTR_W-1:0]   rd_idx;
  logic [NUM_LANES-1:0]              rd_vld;
  entry_t [NUM_LANES-1:0]            rd_ent;

  // in_ready looks only at registered occupancy, never at this cycle's dequeue
  assign in_ready = (count <= CNT_RDY);
  assign enq_num  = (in_ready && in_valid1) ? (in_valid2 ? 2'd2 : 2'd1) : 2'd0;
  assign deq_req  = (deq_num == 2'd3) ? 2'd2 : deq_num;
  assign deq_eff  = ((PTR_W+1)'(deq_req) > count) ? count[1:0] : deq_req;

  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_eff);
      tail  <= tail + PTR_W'(enq_num);
      count <= count + (PTR_W+1)'(enq_num) - (PTR_W+1)'(deq_eff);
    end
  end

  // Storage is not reset; writes are suppressed when the pointers are being cleared
  always_ff @(posedge i_clk) begin
    if (!i_reset && !flush) begin
      if (enq_num != 2'd0) mem[tail] <= '{inst: in_inst1, pc: in_pc1, pred: in_pred1};
      if (enq_num == 2'd2) mem[tail + PTR_W'(1)] <= '{inst: in_inst2, pc: in_pc2, pred: in_pred2};
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_rd
    assign rd_idx[l] = head + PTR_W'(l);
    assign rd_vld[l] = (count > (PTR_W+1)'(l));
    assign rd_ent[l] = rd_vld[l] ? mem[rd_idx[l]] : '{inst: NOP, pc: 32'd0, pred: 1'b0};
  end

  assign out_valid1 = rd_vld[0];
  assign out_valid2 = rd_vld[1];
  assign out_inst1  = rd_ent[0].inst;
  assign out_inst2  = rd_ent[1].inst;
  assign out_pc1    = rd_ent[0].pc;
  assign out_pc2    = rd_ent[1].pc;
  assign out_pred1  = rd_ent[0].pred;
  assign out_pred2  = rd_ent[1].pred;
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8): reset, FWFT order, full/drop,
// wrap-around, simultaneous enq/deq, flush and mid-stream reset.
module tb_inst_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        v1, v2, p1, p2, rdy, ov1, ov2, op1, op2, fl;
  logic [31:0] i1, i2, pc1, pc2, oi1, oi2, opc1, opc2;
  logic [1:0]  dq;
  logic [3:0]  cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_queue #(.DEPTH(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .in_valid1(v1), .in_valid2(v2), .in_inst1(i1), .in_inst2(i2),
    .in_pc1(pc1), .in_pc2(pc2), .in_pred1(p1), .in_pred2(p2), .in_ready(rdy),
    .out_valid1(ov1), .out_valid2(ov2), .out_inst1(oi1), .out_inst2(oi2),
    .out_pc1(opc1), .out_pc2(opc2), .out_pred1(op1), .out_pred2(op2),
    .deq_num(dq), .flush(fl), .count(cnt)
  );

  always #5 clk = ~clk;

  // inst derived from pc, pred = pc[2], so expectations follow from the pc alone
  task automatic drive(input logic a, input logic b, input logic [31:0] pa, input logic [31:0] pb,
                       input logic [1:0] d);
    v1 = a; v2 = b; pc1 = pa; pc2 = pb; i1 = 32'h1000_0000 | pa; i2 = 32'h1000_0000 | pb;
    p1 = pa[2]; p2 = pb[2]; dq = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    fl = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fl = 1'b0; drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    tick(); tick();
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", cnt); end
    n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", rdy); end
    n_cmp++; if ({ov1, ov2} !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b exp 00", {ov1, ov2}); end
    n_cmp++; if (oi1 !== NOP || oi2 !== NOP) begin n_err++; $display("FAIL reset_inst got %h/%h exp %h", oi1, oi2, NOP); end
    n_cmp++; if (opc1 !== 0 || opc2 !== 0 || op1 !== 0 || op2 !== 0) begin n_err++; $display("FAIL reset_pc_pred got %h/%h %b%b exp 0", opc1, opc2, op1, op2); end
  endtask

  task automatic test_basic();
    v1 = 1; v2 = 1; i1 = 32'h0050_0093; pc1 = 32'h100; p1 = 1; i2 = 32'h00A0_0113; pc2 = 32'h104; p2 = 0; dq = 0;
    tick();
    n_cmp++; if (cnt !== 4'd2) begin n_err++; $display("FAIL basic_count got %0d exp 2", cnt); end
    n_cmp++; if (oi1 !== 32'h0050_0093 || opc1 !== 32'h100 || op1 !== 1'b1) begin n_err++; $display("FAIL basic_head got %h@%h p%b", oi1, opc1, op1); end
    n_cmp++; if (oi2 !== 32'h00A0_0113 || opc2 !== 32'h104 || ov2 !== 1'b1) begin n_err++; $display("FAIL basic_head1 got %h@%h v%b", oi2, opc2, ov2); end
    dq = 1; tick();
    n_cmp++; if (oi1 !== 32'h00A0_0113 || opc1 !== 32'h104 || cnt !== 4'd1) begin n_err++; $display("FAIL basic_deq1 got %h@%h cnt %0d", oi1, opc1, cnt); end
    n_cmp++; if (ov2 !== 1'b0 || oi2 !== NOP || opc2 !== 0) begin n_err++; $display("FAIL basic_v2_low got v%b %h %h", ov2, oi2, opc2); end
    dq = 1; tick();
    n_cmp++; if (cnt !== 4'd0 || ov1 !== 1'b0) begin n_err++; $display("FAIL basic_empty got cnt %0d v%b exp 0", cnt, ov1); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h300 + 16*k, 32'h308 + 16*k, 2'd0);
      tick();
    end
    n_cmp++; if (cnt !== 4'd8 || rdy !== 1'b0) begin n_err++; $display("FAIL fill_full got cnt %0d rdy %b exp 8/0", cnt, rdy); end
    drive(1, 1, 32'hDEAD, 32'hBEEF, 2'd0); tick();
    n_cmp++; if (cnt !== 4'd8 || opc1 !== 32'h300) begin n_err++; $display("FAIL fill_drop got cnt %0d pc %h exp 8/300", cnt, opc1); end
    dq = 1; tick();
    n_cmp++; if (cnt !== 4'd7 || rdy !== 1'b0 || opc1 !== 32'h308) begin n_err++; $display("FAIL fill_7 got cnt %0d rdy %b pc %h", cnt, rdy, opc1); end
    dq = 1; tick();
    n_cmp++; if (cnt !== 4'd6 || rdy !== 1'b1 || opc1 !== 32'h310 || op1 !== 1'b0) begin n_err++; $display("FAIL fill_6 got cnt %0d rdy %b pc %h", cnt, rdy, opc1); end
    drive(0, 1, 32'h0, 32'hBAD0, 2'd0); tick();
    n_cmp++; if (cnt !== 4'd6) begin n_err++; $display("FAIL lane2_only got cnt %0d exp 6", cnt); end
    for (int k = 0; k < 3; k++) begin dq = 2; tick(); end
    n_cmp++; if (cnt !== 4'd0 || rdy !== 1'b1) begin n_err++; $display("FAIL fill_drain got cnt %0d exp 0", cnt); end
  endtask

  // head/tail are at 2 on entry; move them to 7 then straddle 7 -> 0
  task automatic test_wrap();
    drive(1, 1, 32'h10, 32'h14, 2'd0); tick();
    drive(1, 1, 32'h18, 32'h1C, 2'd0); tick();
    drive(1, 0, 32'h20, 32'h0, 2'd0); tick();
    dq = 2; tick(); dq = 2; tick(); dq = 1; tick();
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL wrap_prep got cnt %0d exp 0", cnt); end
    drive(1, 1, 32'h200, 32'h204, 2'd0); tick();
    n_cmp++; if (opc1 !== 32'h200 || opc2 !== 32'h204 || oi2 !== 32'h1000_0204) begin n_err++; $display("FAIL wrap_order got %h %h %h", opc1, opc2, oi2); end
    n_cmp++; if (op1 !== 1'b0 || op2 !== 1'b1 || cnt !== 4'd2) begin n_err++; $display("FAIL wrap_pred got %b%b cnt %0d", op1, op2, cnt); end
    dq = 2; tick();
    n_cmp++; if (cnt !== 4'd0 || ov1 !== 1'b0) begin n_err++; $display("FAIL wrap_deq got cnt %0d v%b", cnt, ov1); end
  endtask

  task automatic test_simul();
    drive(1, 1, 32'h400, 32'h404, 2'd0); tick();
    drive(1, 0, 32'h408, 32'h0, 2'd0); tick();
    n_cmp++; if (cnt !== 4'd3) begin n_err++; $display("FAIL simul_prep got cnt %0d exp 3", cnt); end
    drive(1, 1, 32'h40C, 32'h410, 2'd2); tick();
    n_cmp++; if (cnt !== 4'd3 || opc1 !== 32'h408 || opc2 !== 32'h40C) begin n_err++; $display("FAIL simul_enq_deq got cnt %0d pc %h %h", cnt, opc1, opc2); end
    dq = 2; tick();
    n_cmp++; if (cnt !== 4'd1 || opc1 !== 32'h410 || ov2 !== 1'b0) begin n_err++; $display("FAIL simul_deq2 got cnt %0d pc %h v2 %b", cnt, opc1, ov2); end
    dq = 2; tick();
    n_cmp++; if (cnt !== 4'd0 || ov1 !== 1'b0 || rdy !== 1'b1) begin n_err++; $display("FAIL simul_underflow got cnt %0d v%b", cnt, ov1); end
    drive(1, 1, 32'h500, 32'h504, 2'd0); tick();
    dq = 3; tick();
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL deq3_as_2 got cnt %0d exp 0", cnt); end
  endtask

  task automatic test_flush();
    drive(1, 1, 32'h600, 32'h604, 2'd0); tick();
    drive(1, 1, 32'h608, 32'h60C, 2'd0); tick();
    drive(1, 0, 32'h610, 32'h0, 2'd0); tick();
    n_cmp++; if (cnt !== 4'd5) begin n_err++; $display("FAIL flush_prep got cnt %0d exp 5", cnt); end
    drive(1, 1, 32'h700, 32'h704, 2'd2); fl = 1; tick();
    n_cmp++; if (cnt !== 4'd0 || ov1 !== 1'b0 || rdy !== 1'b1 || oi1 !== NOP) begin n_err++; $display("FAIL flush_empty got cnt %0d v%b rdy %b %h", cnt, ov1, rdy, oi1); end
    drive(1, 1, 32'h800, 32'h804, 2'd0); tick();
    n_cmp++; if (cnt !== 4'd2 || opc1 !== 32'h800 || opc2 !== 32'h804) begin n_err++; $display("FAIL flush_redirect got cnt %0d pc %h %h", cnt, opc1, opc2); end
    drive(1, 1, 32'h900, 32'h904, 2'd1); rst = 1; tick();
    n_cmp++; if (cnt !== 4'd0 || {ov1, ov2} !== 2'b00 || rdy !== 1'b1 || opc1 !== 0) begin n_err++; $display("FAIL midreset got cnt %0d v%b%b pc %h", cnt, ov1, ov2, opc1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simul();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
# inst_queue

Two-wide instruction queue between the fetch stage and the dual decoders. Fetch writes up to two instructions (with PC and branch-prediction bit) per cycle. The two decoder lanes read the oldest two entries first-word-fall-through and report how many they consumed. A branch mispredict flushes every entry in one cycle.

## Interface
- DEPTH, 8: number of entries; must be a power of two and ≥4
- PTR_W, $clog2(DEPTH): pointer width; count width is PTR_W+1

- i_clk  in  1  single clock; all state updates on the rising edge
- i_reset  in  1  synchronous, active-high reset
- in_valid1, in_valid2  in  1 each  fetch lanes valid; lane 2 is honoured only together with lane 1
- in_inst1, in_inst2  in  32 each  instruction words
- in_pc1, in_pc2  in  32 each  instruction PCs
- in_pred1, in_pred2  in  1 each  predicted-taken bits
- in_ready  out  1  queue can accept two instructions this cycle
- out_valid1, out_valid2  out  1 each  head entry / head+1 entry present
- out_inst1, out_inst2  out  32 each  head / head+1 instruction; 32'h00000013 (addi x0,x0,0) when the matching valid is low
- out_pc1, out_pc2  out  32 each  matching PCs; 0 when invalid
- out_pred1, out_pred2  out  1 each  matching prediction bits; 0 when invalid
- deq_num  in  2  entries consumed by decode this cycle (0, 1 or 2)
- flush  in  1  mispredict/redirect; discards all contents
- count  out  PTR_W+1  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer of {inst, pc, pred}, not reset.
- State: head, tail (PTR_W bits, wrap modulo DEPTH) and count (0..DEPTH).
- in_ready = (DEPTH − count ≥ 2). It depends only on registered state, not on this cycle's deq_num.
- Enqueue number = in_ready ? (in_valid1 + (in_valid1 & in_valid2)) : 0.
- Lane 1 is written at tail, lane 2 at tail+1; tail advances by the enqueue number.
- in_valid2 without in_valid1 is a protocol violation: nothing is written. Writes while in_ready=0 are dropped; fetch must hold its data.
- out_valid1 = (count ≥ 1), out_valid2 = (count ≥ 2). Output data is read combinationally at head and head+1.
- Effective dequeue = min(deq_num, count). deq_num=3 is treated as 2. head advances by the effective dequeue.
- Next count = count + enqueue number − effective dequeue. Simultaneous enqueue and dequeue are both applied in the same cycle.
- Wrap-around: tail+1 and head+1 are computed modulo DEPTH. A two-entry write or read straddling index DEPTH−1 → 0 must work.
- flush: head, tail and count go to 0 on that edge. Any enqueue and dequeue in the same cycle are discarded. flush has priority over everything except i_reset.
- i_reset: head=tail=count=0 at the edge, regardless of other inputs, including mid-operation.

## Timing
- Reset values: count=0, in_ready=1, out_valid1=out_valid2=0, out_inst1=out_inst2=32'h00000013, out_pc*=0, out_pred*=0.
- Enqueue latency is one cycle: an entry written at edge N is visible on out_* during cycle N+1.
- Dequeue takes effect at the edge. The next entries appear in the following cycle with no bubble.
- After flush at edge N, the outputs show empty from cycle N+1 and in_ready=1. The fetch redirect may enqueue in cycle N+1.
- Full (count=DEPTH) or DEPTH−1: in_ready=0. At most 2 entries drain per cycle, so in_ready returns in the cycle after count drops to DEPTH−2 or below.
- Throughput: sustained 2 in / 2 out per cycle with no stall when count stays between 2 and DEPTH−2.

## Test plan
- Reset then idle: count=0, in_ready=1, out_valid1/2=0, out_inst1=out_inst2=0x00000013.
- Enqueue {0x00500093 @pc 0x100, 0x00A00113 @0x104} with deq_num=0 → next cycle count=2, out_inst1=0x00500093, out_pc2=0x104. Then deq_num=1 → out_inst1=0x00A00113, out_valid2=0, count=1.
- Fill DEPTH=8 with 4 double enqueues, deq_num=0 → count=8, in_ready=0. A further enqueue is dropped (count stays 8). deq_num=2 → count=6, in_ready=1.
- Wrap: advance head/tail to 7, enqueue pcs 0x200/0x204 → stored at indices 7 and 0. deq_num=2 → out_pc1=0x200, out_pc2=0x204, in order.
- Simultaneous: count=3, enqueue 2 and deq_num=2 in the same cycle → count=3, head+2. deq_num=2 with count=1 → count=0, no underflow.
- flush with count=5 plus a concurrent enqueue and deq_num=2 → next cycle count=0, out_valid1=0, in_ready=1. Then i_reset asserted mid-stream → same empty state.
